mem_ctrl: RTL

Data-memory responder for the MEM stage. It accepts one load or store request at a time from the MEM stage (chip-enable, address, write data, size). It serves the request over a byte-wide synchronous RAM port, one byte per cycle, little-endian. It holds the pipeline with a stall request until the access completes, then returns load data, sign- or zero-extended.

---
 rtl/mem_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : MEM-stage data-memory responder. Serves one load/store at a
//               time over a byte-wide synchronous RAM, little-endian, and
//               stalls the pipeline until the access completes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ce,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    output logic              stall_req,
    output logic              rsp_done,
    output logic [31:0]       rsp_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        r_we;
    logic        r_sext;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rbuf;
    logic [31:0] r_rdata;
    logic [31:0] w_rbuf_nxt;
    logic [31:0] w_rdata_ext;
    logic [31:0] w_addr_sum;
    logic [2:0]  w_cnt_m1;
    logic [2:0]  w_nbytes;
    logic        w_capture;
    logic        w_accept;
    logic        w_unused;

    function automatic logic [2:0] size_to_n(input logic [1:0] sz);
        case (sz)
            2'd0:    size_to_n = 3'd1;
            2'd1:    size_to_n = 3'd2;
            default: size_to_n = 3'd4;
        endcase
    endfunction

    assign w_nbytes   = size_to_n(r_size);
    assign w_addr_sum = r_addr + {29'd0, r_cnt};
    assign w_cnt_m1   = r_cnt - 3'd1;
    assign w_accept   = (r_state == ST_IDLE) && req_ce;
    assign w_unused   = ^{req_addr, w_addr_sum, w_cnt_m1[2]};

    // Read buffer with the byte arriving this cycle merged in, then extended
    always_comb begin
        w_rbuf_nxt = r_rbuf;
        if (w_capture) begin
            w_rbuf_nxt[{w_cnt_m1[1:0], 3'b000} +: 8] = ram_din;
        end
        case (r_size)
            2'd0:    w_rdata_ext = {{24{r_sext & w_rbuf_nxt[7]}},  w_rbuf_nxt[7:0]};
            2'd1:    w_rdata_ext = {{16{r_sext & w_rbuf_nxt[15]}}, w_rbuf_nxt[15:0]};
            default: w_rdata_ext = w_rbuf_nxt;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        stall_req   = 1'b0;
        rsp_done    = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = '0;
        ram_dout    = 8'd0;
        case (r_state)
            ST_IDLE: begin
                if (req_ce) begin
                    stall_req = 1'b1;
                    ram_addr  = req_addr[RAM_AW-1:0];
                    if (req_we) begin
                        ram_we   = 1'b1;
                        ram_dout = req_wdata[7:0];
                    end
                    if (req_we && (req_size == 2'd0)) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = 3'd1;
                    end
                end
            end
            ST_BUSY: begin
                stall_req = 1'b1;
                ram_addr  = w_addr_sum[RAM_AW-1:0];
                w_cnt_nxt = r_cnt + 3'd1;
                if (r_we) begin
                    ram_we   = 1'b1;
                    ram_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                    if (r_cnt == (w_nbytes - 3'd1)) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = 3'd0;
                    end
                end else begin
                    // Loads see ram_din one cycle late, so the last cycle only captures
                    w_capture = 1'b1;
                    if (r_cnt == w_nbytes) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_nxt   = 3'd0;
                    end
                end
            end
            ST_DONE: begin
                rsp_done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
        // Reset must silence the strobes at once, even with req_ce high
        if (rst) begin
            stall_req = 1'b0;
            rsp_done  = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = '0;
            ram_dout  = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_we    <= 1'b0;
            r_sext  <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rbuf  <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_sext  <= req_sext;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_capture) begin
                r_rbuf <= w_rbuf_nxt;
                if (w_state_nxt == ST_DONE) begin
                    r_rdata <= w_rdata_ext;
                end
            end
        end
    end

    assign rsp_rdata = r_rdata;

endmodule
`default_nettype wire
